// File: rtl/lzc_rr_arbiter.sv
// Round-robin arbiter over NumIn requesters using two trailing-zero lzc searches.
// Optional grant lock while stalled: define LZC_RR_ARB_LOCK_EN.

module lzc #(
  parameter int Width    = 2,
  parameter bit Mode     = 1'b0,
  parameter int CntWidth = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0]    in_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                empty_o
);

  // Mode 0 reports the lowest set bit, mode 1 the leading-zero count.
  always_comb begin
    cnt_o   = '0;
    empty_o = ~|in_i;
    if (Mode == 1'b0) begin
      for (int i = Width - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CntWidth'(i);
      end
    end else begin
      for (int i = 0; i < Width; i++) begin
        if (in_i[i]) cnt_o = CntWidth'(Width - 1 - i);
      end
    end
  end

endmodule

module lzc_rr_arbiter #(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdxWidth  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic [NumIn-1:0]                req_i,
  output logic [NumIn-1:0]                gnt_o,
  input  logic [NumIn-1:0][DataWidth-1:0] data_i,
  output logic                            req_o,
  input  logic                            gnt_i,
  output logic [DataWidth-1:0]            data_o,
  output logic [IdxWidth-1:0]             idx_o
);

  logic [IdxWidth-1:0] rr_q, rr_d;
  logic [IdxWidth-1:0] sel_idx_s;
  logic                handshake_s;

  if (NumIn == 1) begin : g_single
    assign sel_idx_s = '0;
  end else begin : g_multi
    logic [NumIn-1:0]    mask_s;
    logic [NumIn-1:0]    masked_req_s;
    logic [IdxWidth-1:0] masked_cnt_s, all_cnt_s;
    logic                masked_empty_s, all_empty_s;

    // Requests at or above the priority pointer get first pick.
    always_comb begin
      mask_s = '0;
      for (int i = 0; i < int'(NumIn); i++) begin
        mask_s[i] = (IdxWidth'(i) >= rr_q);
      end
      masked_req_s = req_i & mask_s;
    end

    lzc #(.Width(NumIn), .Mode(1'b0), .CntWidth(IdxWidth)) u_lzc_masked (
      .in_i    (masked_req_s),
      .cnt_o   (masked_cnt_s),
      .empty_o (masked_empty_s)
    );

    lzc #(.Width(NumIn), .Mode(1'b0), .CntWidth(IdxWidth)) u_lzc_all (
      .in_i    (req_i),
      .cnt_o   (all_cnt_s),
      .empty_o (all_empty_s)
    );

    // Fall back to the unmasked search; never expose the all-zero count.
    always_comb begin
      if (!masked_empty_s) begin
        sel_idx_s = masked_cnt_s;
      end else if (!all_empty_s) begin
        sel_idx_s = all_cnt_s;
      end else begin
        sel_idx_s = '0;
      end
    end
  end

`ifdef LZC_RR_ARB_LOCK_EN
  logic                lock_q, lock_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;

  // A stalled grant freezes the selection until it completes or is withdrawn.
  always_comb begin
    if (lock_q) begin
      idx_o = lock_idx_q;
      req_o = req_i[lock_idx_q];
    end else begin
      idx_o = sel_idx_s;
      req_o = |req_i;
    end
  end

  // Lock re-arms every stalled cycle; a drop, handshake or flush releases it.
  always_comb begin
    if (flush_i) begin
      lock_d     = 1'b0;
      lock_idx_d = '0;
    end else if (req_o && !gnt_i) begin
      lock_d     = 1'b1;
      lock_idx_d = idx_o;
    end else begin
      lock_d     = 1'b0;
      lock_idx_d = lock_idx_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

`ifndef COMMON_CELLS_ASSERTS_OFF
  lzc_rr_arbiter_lock_chk #(.NumIn(NumIn), .IdxWidth(IdxWidth)) u_lock_chk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .lock_q     (lock_q),
    .lock_idx_q (lock_idx_q),
    .req_i      (req_i)
  );
`endif
`else
  always_comb begin
    idx_o = sel_idx_s;
    req_o = |req_i;
  end
`endif

  // Payload mux and one-hot grant steering.
  always_comb begin
    gnt_o        = '0;
    gnt_o[idx_o] = gnt_i & req_o;
    data_o       = data_i[idx_o];
  end

  assign handshake_s = req_o & gnt_i;

  // Pointer moves just past the winner on a handshake; flush wins over it.
  always_comb begin
    if (flush_i) begin
      rr_d = '0;
    end else if (handshake_s) begin
      rr_d = (idx_o == IdxWidth'(NumIn - 1)) ? '0 : idx_o + IdxWidth'(1);
    end else begin
      rr_d = rr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

`ifdef LZC_RR_ARB_LOCK_EN
`ifndef COMMON_CELLS_ASSERTS_OFF
module lzc_rr_arbiter_lock_chk #(
  parameter int unsigned NumIn    = 4,
  parameter int unsigned IdxWidth = 2
) (
  input logic                clk_i,
  input logic                rst_ni,
  input logic                lock_q,
  input logic [IdxWidth-1:0] lock_idx_q,
  input logic [NumIn-1:0]    req_i
);

  // A locked requester must keep requesting until it is granted.
  a_lock_req_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> req_i[lock_idx_q])
    else $error("locked requester dropped its request");

endmodule
`endif
`endif

// File: tb/tb_lzc_rr_arbiter.sv
// Scoreboard bench for lzc_rr_arbiter: driver pushes model predictions,
// a negedge monitor pops and compares them against the DUT outputs.

module tb_lzc_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_i = 1'b0;
  logic [N-1:0]      req_i = '0;
  logic [N-1:0]      gnt_o;
  logic [N-1:0][DW-1:0] data_i;
  logic              req_o;
  logic              gnt_i = 1'b0;
  logic [DW-1:0]     data_o;
  logic [1:0]        idx_o;

  lzc_rr_arbiter #(.NumIn(N), .DataWidth(DW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .req_i   (req_i),
    .gnt_o   (gnt_o),
    .data_i  (data_i),
    .req_o   (req_o),
    .gnt_i   (gnt_i),
    .data_o  (data_o),
    .idx_o   (idx_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       req;
    logic [3:0] gnt;
    int         idx;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: priority pointer and (optionally) the lock.
  int   m_ptr = 0;
  bit   m_lock = 0;
  int   m_lock_idx = 0;
  exp_t last;
  bit   last_valid = 0;
  bit   last_gnt = 0;
  bit   last_flush = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t predict(input logic [3:0] r, input bit g, input string tag);
    exp_t e;
    e.tag = tag;
    e.idx = 0;
    e.req = (r != 4'b0000);
    if (m_lock) begin
      e.idx = m_lock_idx;
      e.req = r[m_lock_idx];
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (r[(m_ptr + k) % N]) e.idx = (m_ptr + k) % N;
      end
    end
    e.gnt  = (e.req && g) ? (4'b0001 << e.idx) : 4'b0000;
    e.data = data_i[e.idx];
    return e;
  endfunction

  // Advance the model by the clock edge that just happened.
  task automatic model_edge();
    if (!last_valid) return;
    if (last_flush) begin
      m_ptr  = 0;
      m_lock = 0;
    end else begin
      if (last.req && last_gnt) m_ptr = (last.idx + 1) % N;
`ifdef LZC_RR_ARB_LOCK_EN
      m_lock     = last.req && !last_gnt;
      m_lock_idx = last.idx;
`endif
    end
  endtask

  task automatic step(input logic [3:0] r, input bit g, input bit f, input string tag);
    @(posedge clk);
    if (rst_ni) model_edge();
    #1;
    rst_ni  = 1'b1;
    req_i   = r;
    gnt_i   = g;
    flush_i = f;
    for (int i = 0; i < N; i++) data_i[i] = $urandom;
    last       = predict(r, g, tag);
    last_gnt   = g;
    last_flush = f;
    last_valid = 1;
    q.push_back(last);
  endtask

  // Monitor: compare every presented output cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".req_o"}, {31'd0, req_o}, {31'd0, e.req});
        chk({e.tag, ".gnt_o"}, {28'd0, gnt_o}, {28'd0, e.gnt});
        chk({e.tag, ".idx_o"}, {30'd0, idx_o}, 32'(e.idx));
        chk({e.tag, ".data_o"}, data_o, e.data);
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) data_i[i] = $urandom;
    repeat (3) @(posedge clk);

    // Reset state with no requests, then fair rotation.
    step(4'b0000, 1'b0, 1'b0, "reset");
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b1, 1'b0, "rotate");

    // Wrap-around: grant idx 2 then a lower-only request set.
    step(4'b0100, 1'b1, 1'b0, "wrap_g2");
    step(4'b0011, 1'b1, 1'b0, "wrap_low");
    step(4'b0011, 1'b1, 1'b0, "wrap_after");

    // Lock scenario from pointer 0.
    step(4'b0000, 1'b0, 1'b1, "flush0");
    step(4'b0110, 1'b0, 1'b0, "lock_setup");
    step(4'b0111, 1'b0, 1'b0, "lock_new");
    step(4'b0111, 1'b1, 1'b0, "lock_gnt");
    step(4'b0111, 1'b1, 1'b0, "lock_post");

    // Flush during a stall on idx 2.
    step(4'b0000, 1'b0, 1'b1, "flush1");
    step(4'b1111, 1'b1, 1'b0, "fl_a");
    step(4'b1111, 1'b1, 1'b0, "fl_b");
    step(4'b1100, 1'b0, 1'b0, "fl_stall");
    step(4'b1100, 1'b0, 1'b1, "fl_flush");
    step(4'b1100, 1'b0, 1'b0, "fl_after");
    step(4'b0011, 1'b1, 1'b0, "fl_low");

    // Asynchronous reset in the middle of a stall on idx 2.
    step(4'b0000, 1'b0, 1'b1, "ar_flush");
    step(4'b1111, 1'b1, 1'b0, "ar_a");
    step(4'b1111, 1'b1, 1'b0, "ar_b");
    step(4'b1111, 1'b0, 1'b0, "ar_stall");
    @(negedge clk);
    #1;
    rst_ni     = 1'b0;
    m_ptr      = 0;
    m_lock     = 0;
    last_valid = 0;
    #1;
    chk("async_rst.idx_o", {30'd0, idx_o}, 32'd0);
    chk("async_rst.gnt_o", {28'd0, gnt_o}, 32'd0);
    chk("async_rst.req_o", {31'd0, req_o}, 32'd1);
    step(4'b1111, 1'b1, 1'b0, "ar_release");
    step(4'b1111, 1'b1, 1'b0, "ar_next");

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), "rand");
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
